uart_packet_decoder: RTL

Consumes the byte stream produced by the UART deserializer (8-bit data plus a one-cycle write strobe) and frames it into command packets. Packet format: SYNC (0xA5), CMD, LEN, LEN payload bytes, CHK. A valid packet has its payload buffered, then released on a valid/ready stream with a last marker. A bad packet is discarded and flagged. The block sits between the UART receive path and the receiver's command/register logic.

---
 rtl/uart_packet_decoder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_packet_decoder.sv
// Frames the UART receive byte stream (SYNC, CMD, LEN, payload, CHK) into buffered command packets.
// Optional inter-byte timeout: define UART_PKT_TIMEOUT_EN.
module uart_packet_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       wr_en_i,
  output logic [7:0] cmd_o,
  output logic [7:0] len_o,
  output logic       pkt_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  output logic       out_last_o,
  input  logic       out_ready_i,
  output logic       err_chk_o,
  output logic       err_len_o,
  output logic       err_timeout_o,
  output logic       drop_o,
  output logic       busy_o
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_packet_decoder: parameter out of range");
  end

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      cmd_cur_q, cmd_cur_d;
  logic [7:0]      len_cur_q, len_cur_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [IW-1:0]   wr_next_s, rd_next_s;
  logic [7:0]      buf_q [MAX_LEN];
  logic            buf_we_s;
  logic            timeout_s;

  logic [7:0]      cmd_q, cmd_d, len_q, len_d, out_data_q, out_data_d;
  logic            pkt_q, pkt_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            err_chk_q, err_chk_d, err_len_q, err_len_d, drop_q, drop_d;
  logic            busy_q, busy_d;

  assign wr_next_s = wr_idx_q + IW'(1);
  assign rd_next_s = rd_idx_q + IW'(1);

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timed_s;
  logic          err_to_q;

  assign timed_s   = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_s = timed_s && !wr_en_i && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmr_d = tmr_q + TW'(1);
    if (!timed_s || wr_en_i || timeout_s) tmr_d = '0;
    else                                  tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      err_to_q <= timeout_s;
    end
  end

  assign err_timeout_o = err_to_q;
`else
  assign timeout_s     = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cmd_cur_d   = cmd_cur_q;
    len_cur_d   = len_cur_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    buf_we_s    = 1'b0;
    cmd_d       = cmd_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_d       = 1'b0;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    drop_d      = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (wr_en_i && (data_i == SYNC_BYTE)) begin
          state_d = S_CMD;
          sum_d   = 8'h00;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_CMD: begin
        if (wr_en_i) begin
          cmd_cur_d = data_i;
          sum_d     = data_i;
          state_d   = S_LEN;
        end else begin
          state_d = S_CMD;
        end
      end
      S_LEN: begin
        if (wr_en_i) begin
          len_cur_d = data_i;
          sum_d     = sum_q + data_i;
          wr_idx_d  = '0;
          if (data_i > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else if (data_i == 8'h00) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (wr_en_i) begin
          buf_we_s = 1'b1;
          wr_idx_d = wr_next_s;
          sum_d    = sum_q + data_i;
          if (8'(wr_next_s) == len_cur_q) state_d = S_CHK;
          else                            state_d = S_PAYLOAD;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (wr_en_i) begin
          if (data_i == sum_q) begin
            cmd_d    = cmd_cur_q;
            len_d    = len_cur_q;
            pkt_d    = 1'b1;
            rd_idx_d = '0;
            // First payload byte goes out together with the accept pulse.
            if (len_cur_q != 8'h00) begin
              state_d     = S_DRAIN;
              out_valid_d = 1'b1;
              out_data_d  = buf_q[AW'(0)];
              out_last_d  = (len_cur_q == 8'h01);
            end else begin
              state_d = S_HUNT;
            end
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_DRAIN: begin
        if (wr_en_i) drop_d = 1'b1;
        else         drop_d = 1'b0;
        if (out_valid_q && out_ready_i) begin
          if (out_last_q) begin
            state_d     = S_HUNT;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_idx_d   = rd_next_s;
            out_data_d = buf_q[rd_next_s[AW-1:0]];
            out_last_d = (8'(rd_next_s) == (len_cur_q - 8'h01));
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (timeout_s) state_d = S_HUNT;
    else           busy_d  = 1'b0;
    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      sum_q       <= 8'h00;
      cmd_cur_q   <= 8'h00;
      len_cur_q   <= 8'h00;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_q       <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cmd_cur_q   <= cmd_cur_d;
      len_cur_q   <= len_cur_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_q       <= pkt_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we_s) buf_q[wr_idx_q[AW-1:0]] <= data_i;
  end

  assign cmd_o       = cmd_q;
  assign len_o       = len_q;
  assign pkt_o       = pkt_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign err_chk_o   = err_chk_q;
  assign err_len_o   = err_len_q;
  assign drop_o      = drop_q;
  assign busy_o      = busy_q;

endmodule
